// File: rtl/xenyx_regfile_pkg.sv
// xenyx_regfile_pkg
// Shared definitions for the register file, its writeback arbiter and the
// hazard logic: data/address widths, register count, the hard-wired zero
// register and a constant-width helper.
package xenyx_regfile_pkg;

   localparam int XLEN   = 32;
   localparam int AW     = 5;
   localparam int N_REGS = 32;

   localparam logic [AW-1:0] ZERO_REG = 5'b00000;

   // Bits needed to index n items; never less than 1 so it can size a port.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin priority picker. Searches req starting at ptr,
// wrapping modulo N, and reports the first set bit.
//   req : request vector
//   ptr : highest-priority index (must be < N)
//   gnt : one-hot grant, or zero when nothing requests
//   idx : index of the granted bit (0 when none)
//   any : at least one request present
module rr_picker
   import xenyx_regfile_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;

   // NOTE: every output of a combinational block gets a default before the
   // loop; otherwise paths that never assign it would infer a latch.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Round-robin arbiter sharing the register file write port among N_REQ
// writeback requesters. The winner's address/data are registered and
// presented to the register file one cycle after the handshake. Writes to
// x0 are consumed but not enabled. A saturating counter records cycles with
// two or more simultaneous requests.
//   clk, rst_n     : clock, synchronous active-low reset
//   req_valid      : per-requester write request
//   req_addr/data  : packed per-requester destination / data
//   req_ready      : combinational one-hot (or zero) grant
//   wb_stall       : blocks any grant this cycle
//   reg_write, write_addr, write_data : registered register-file write port
//   grant_id       : requester whose write is on the port
//   contention_cnt : saturating count of contended cycles
module regfile_wb_arbiter
   import xenyx_regfile_pkg::clog2;
   import xenyx_regfile_pkg::ZERO_REG;
#(
   parameter  int N_REQ = 4,
   parameter  int XLEN  = xenyx_regfile_pkg::XLEN,
   parameter  int AW    = xenyx_regfile_pkg::AW,
   parameter  int CNT_W = 16,
   localparam int IDX_W = clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*AW-1:0]   req_addr,
   input  logic [N_REQ*XLEN-1:0] req_data,
   output logic [N_REQ-1:0]      req_ready,
   input  logic                  wb_stall,
   output logic                  reg_write,
   output logic [AW-1:0]         write_addr,
   output logic [XLEN-1:0]       write_data,
   output logic [IDX_W-1:0]      grant_id,
   output logic [CNT_W-1:0]      contention_cnt
);

   logic [IDX_W-1:0] rr_ptr_q,     rr_ptr_d;
   logic             reg_write_q,  reg_write_d;
   logic [AW-1:0]    write_addr_q, write_addr_d;
   logic [XLEN-1:0]  write_data_q, write_data_d;
   logic [IDX_W-1:0] grant_id_q,   grant_id_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;

   logic [N_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             grant_ok;
   logic             transfer;
   logic             contended;
   logic [AW-1:0]    win_addr;
   logic [XLEN-1:0]  win_data;

   rr_picker #(.N(N_REQ)) u_picker (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // rst_n gates the grant combinationally so a requester never sees ready
   // in a cycle whose edge is going to reset the arbiter.
   assign grant_ok  = rst_n & ~wb_stall;
   assign req_ready = grant_ok ? pick_gnt : '0;
   assign transfer  = grant_ok & pick_any;

   assign win_addr  = req_addr[int'(pick_idx)*AW +: AW];
   assign win_data  = req_data[int'(pick_idx)*XLEN +: XLEN];
   assign contended = $countones(req_valid) >= 2;

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      reg_write_d  = 1'b0;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      grant_id_d   = grant_id_q;
      if (transfer) begin
         rr_ptr_d     = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
         write_addr_d = win_addr;
         write_data_d = win_data;
         grant_id_d   = pick_idx;
         // An x0 write is consumed (the requester is released) but dropped.
         reg_write_d  = (win_addr != AW'(ZERO_REG));
      end
      cnt_d = (contended && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q     <= '0;
         reg_write_q  <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         grant_id_q   <= '0;
         cnt_q        <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         reg_write_q  <= reg_write_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         grant_id_q   <= grant_id_d;
         cnt_q        <= cnt_d;
      end
   end

   assign reg_write      = reg_write_q;
   assign write_addr     = write_addr_q;
   assign write_data     = write_data_q;
   assign grant_id       = grant_id_q;
   assign contention_cnt = cnt_q;

endmodule
